// File: rtl/tpu_seq_pkg.sv
// Shared types and constants for the TPU batch sequencer: FSM states,
// status/ctrl bit positions and default thresholds.
package tpu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_ABORT  = 2;
  localparam int ST_TMO    = 3;
  localparam int ST_LUTREJ = 4;
  localparam int ST_STALL  = 5;

  localparam int CTRL_START = 0;
  localparam int CTRL_LUT   = 1;
  localparam int CTRL_ABORT = 7;

  localparam int FIFO_HI_DEF     = 1000;
  localparam int TIMEOUT_CYC_DEF = 65535;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/tpu_seq_ctrl_edge.sv
// Registers the software control word once and derives the start edge,
// LUT-write toggle and abort level from the registered copy.
module tpu_seq_ctrl_edge
  import tpu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ctrl,
  output logic       start,
  output logic       lut_tog,
  output logic       abort
);

  logic [2:0] cur;
  logic [1:0] prv;
  logic       unused_ctrl;

  assign unused_ctrl = ^ctrl[6:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
      prv <= '0;
    end else begin
      cur <= {ctrl[CTRL_ABORT], ctrl[CTRL_LUT], ctrl[CTRL_START]};
      prv <= cur[1:0];
    end
  end

  assign start   = cur[0] & ~prv[0];
  assign lut_tog = cur[1] ^ prv[1];
  assign abort   = cur[2];

endmodule

// File: rtl/tpu_batch_sequencer.sv
// Batch sequencer: issues batnum x prodnum TPU products with FIFO backpressure,
// per-product timeout, abort, ECC result counting and LUT write forwarding.
module tpu_batch_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int FIFO_HI     = FIFO_HI_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)(
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [7:0]  ctrl,
  input  logic [9:0]  batnum,
  input  logic [9:0]  prodnum,
  input  logic [10:0] lut_adr,
  input  logic [31:0] lut_data,
  input  logic [9:0]  fifo_used,
  input  logic        tpu_done,
  input  logic [2:0]  ec_flags,
  output logic        lut_wr_en,
  output logic [10:0] lut_wr_adr,
  output logic [31:0] lut_wr_data,
  output logic        tpu_start,
  output logic        busy,
  output logic [19:0] err_cnt,
  output logic [7:0]  status
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t      state_q, state_d;
  logic        start, lut_tog, abort;
  logic [9:0]  batnum_q, prodnum_q, bat, prod;
  logic [9:0]  corr_cnt, uncorr_cnt;
  logic [TW-1:0] tmo;
  logic        done_f, abort_f, tmo_f, lut_rej;
  logic        stall, go, fire, take_done, tmo_exp, last_prod, last_bat;

  tpu_seq_ctrl_edge u_edge (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .ctrl    (ctrl),
    .start   (start),
    .lut_tog (lut_tog),
    .abort   (abort)
  );

  assign stall     = (state_q == S_ISSUE) && (32'(fifo_used) >= FIFO_HI);
  assign last_prod = (prod + 10'd1) == prodnum_q;
  assign last_bat  = (bat + 10'd1) == batnum_q;

  always_comb begin
    state_d   = state_q;
    go        = 1'b0;
    fire      = 1'b0;
    take_done = 1'b0;
    tmo_exp   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start together with abort is treated as a glitch and dropped
        if (start && !abort) begin
          go      = 1'b1;
          state_d = (batnum == 10'd0 || prodnum == 10'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) state_d = S_IDLE;
        else if (!stall) begin
          fire    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) state_d = S_IDLE;
        else if (tpu_done) begin
          take_done = 1'b1;
          state_d   = (last_prod && last_bat) ? S_DONE : S_ISSUE;
        end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
          tmo_exp = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      tpu_start   <= 1'b0;
      lut_wr_en   <= 1'b0;
      lut_wr_adr  <= '0;
      lut_wr_data <= '0;
      batnum_q    <= '0;
      prodnum_q   <= '0;
      bat         <= '0;
      prod        <= '0;
      corr_cnt    <= '0;
      uncorr_cnt  <= '0;
      tmo         <= '0;
      done_f      <= 1'b0;
      abort_f     <= 1'b0;
      tmo_f       <= 1'b0;
      lut_rej     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tpu_start <= fire;
      lut_wr_en <= lut_tog && (state_q == S_IDLE);
      if (lut_tog && state_q == S_IDLE) begin
        lut_wr_adr  <= lut_adr;
        lut_wr_data <= lut_data;
      end
      if (go) begin
        batnum_q   <= batnum;
        prodnum_q  <= prodnum;
        bat        <= '0;
        prod       <= '0;
        corr_cnt   <= '0;
        uncorr_cnt <= '0;
        done_f     <= 1'b0;
        abort_f    <= 1'b0;
        tmo_f      <= 1'b0;
        lut_rej    <= 1'b0;
      end
      if (lut_tog && state_q != S_IDLE) lut_rej <= 1'b1;
      if (fire) tmo <= '0;
      else if (state_q == S_WAIT) tmo <= tmo + TW'(1);
      if (take_done) begin
        if (last_prod) begin
          prod <= '0;
          bat  <= bat + 10'd1;
        end else begin
          prod <= prod + 10'd1;
        end
        if (ec_flags[2])      uncorr_cnt <= sat_inc(uncorr_cnt);
        else if (ec_flags[1]) corr_cnt   <= sat_inc(corr_cnt);
      end
      if (abort && (state_q == S_ISSUE || state_q == S_WAIT)) abort_f <= 1'b1;
      if (tmo_exp) tmo_f <= 1'b1;
      // raise done on entry so it is already visible while in DONE
      if (state_d == S_DONE && state_q != S_DONE) done_f <= 1'b1;
    end
  end

  assign busy    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign err_cnt = {uncorr_cnt, corr_cnt};
  assign status  = {state_q, stall, lut_rej, tmo_f, abort_f, done_f, busy};

endmodule

// File: tb/tb_tpu_batch_sequencer.sv
// Scoreboard bench for tpu_batch_sequencer: expected LUT writes and batch
// completions are queued by the stimulus and checked by a monitor.
module tb_tpu_batch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ctl;
  logic [9:0]  batnum, prodnum, fifo_used;
  logic [10:0] lut_adr;
  logic [31:0] lut_data;
  logic        tpu_done;
  logic [2:0]  ec_flags;
  logic        lut_wr_en, tpu_start, busy;
  logic [10:0] lut_wr_adr;
  logic [31:0] lut_wr_data;
  logic [19:0] err_cnt;
  logic [7:0]  status;

  always #5 clk = ~clk;

  logic       auto_done = 1'b0, man_done = 1'b0;
  logic [2:0] auto_flags = 3'b0, man_flags = 3'b0;
  assign tpu_done = auto_done | man_done;
  assign ec_flags = auto_done ? auto_flags : man_flags;

  typedef struct {
    logic [3:0]  sticky;
    logic [19:0] err;
    int          starts;
  } done_t;

  done_t       done_q[$];
  logic [42:0] lut_q[$];
  logic [2:0]  flag_q[$];
  int          total = 0, bad = 0, n_start = 0;
  bit          resp_en = 1'b0;
  int          resp_dly = 1;
  logic [2:0]  resp_flags = 3'b0;

  tpu_batch_sequencer #(.FIFO_HI(1000), .TIMEOUT_CYC(16)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .ctrl          (ctl),
    .batnum        (batnum),
    .prodnum       (prodnum),
    .lut_adr       (lut_adr),
    .lut_data      (lut_data),
    .fifo_used     (fifo_used),
    .tpu_done      (tpu_done),
    .ec_flags      (ec_flags),
    .lut_wr_en     (lut_wr_en),
    .lut_wr_adr    (lut_wr_adr),
    .lut_wr_data   (lut_wr_data),
    .tpu_start     (tpu_start),
    .busy          (busy),
    .err_cnt       (err_cnt),
    .status        (status)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a write or a completion
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (tpu_start) n_start++;
      if (lut_wr_en) begin
        if (lut_q.size() == 0) begin
          total++; bad++;
          $display("FAIL lut_wr_unexpected: got %0h expected none", {lut_wr_adr, lut_wr_data});
        end else chk("lut_wr", {lut_wr_adr, lut_wr_data}, lut_q.pop_front());
      end
      if (status[7:6] == 2'd3) begin
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got status %0h expected none", status);
        end else begin
          done_t e;
          e = done_q.pop_front();
          chk("done_sticky", status[4:1], e.sticky);
          chk("done_err", err_cnt, e.err);
          chk("done_starts", n_start, e.starts);
        end
      end
    end
  end

  // TPU model: answers each tpu_start after resp_dly cycles
  initial forever begin
    logic [2:0] f;
    @(negedge clk);
    if (tpu_start && resp_en) begin
      if (flag_q.size() != 0) f = flag_q.pop_front();
      else f = resp_flags;
      repeat (resp_dly) @(posedge clk);
      #1 auto_flags = f; auto_done = 1'b1;
      @(posedge clk);
      #1 auto_done = 1'b0; auto_flags = 3'b0;
    end
  end

  task automatic wait_state(input logic [1:0] s, input int max, input string nm);
    int i = 0;
    while (status[7:6] !== s && i < max) begin @(negedge clk); i++; end
    if (status[7:6] !== s) begin
      total++; bad++;
      $display("FAIL %s: got state %0d expected %0d within %0d cycles", nm, status[7:6], s, max);
    end
  endtask

  task automatic wait_start(input int max, input string nm);
    int i = 0;
    while (tpu_start !== 1'b1 && i < max) begin @(negedge clk); i++; end
    if (tpu_start !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s: got no tpu_start expected one within %0d cycles", nm, max);
    end
  endtask

  task automatic do_start(input logic [9:0] b, input logic [9:0] p);
    batnum = b; prodnum = p;
    ctl[0] = 1'b0;
    @(negedge clk);
    ctl[0] = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_done(input logic [3:0] sticky, input logic [19:0] err, input int nstart);
    done_t e;
    e.sticky = sticky; e.err = err; e.starts = n_start + nstart;
    done_q.push_back(e);
  endtask

  initial begin
    int w, n0;
    rst_n = 1'b0; ctl = 8'h00; batnum = '0; prodnum = '0; fifo_used = '0;
    lut_adr = '0; lut_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_lut", {lut_wr_en, lut_wr_adr, lut_wr_data}, 64'h0);
    chk("reset_ctl", {tpu_start, busy, err_cnt, status}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // LUT write in IDLE
    lut_adr = 11'h2A5; lut_data = 32'hDEADBEEF;
    lut_q.push_back({11'h2A5, 32'hDEADBEEF});
    ctl[1] = ~ctl[1];
    repeat (4) @(negedge clk);
    chk("lut_drained", lut_q.size(), 0);

    // 2 batches x 3 products
    resp_en = 1'b1; resp_dly = 4; resp_flags = 3'b000;
    push_done(4'b0001, 20'h0, 6);
    do_start(10'd2, 10'd3);
    wait_state(2'd3, 200, "batch_done");
    @(negedge clk);
    chk("batch_idle_state", status[7:6], 2'd0);
    chk("batch_done_bit", status[1], 1'b1);
    chk("batch_busy", busy, 1'b0);

    // LUT toggle while busy is rejected
    push_done(4'b1001, 20'h0, 2);
    do_start(10'd1, 10'd2);
    wait_state(2'd2, 20, "rej_wait");
    lut_adr = 11'h011; lut_data = 32'h12345678;
    ctl[1] = ~ctl[1];
    wait_state(2'd3, 100, "rej_done");
    @(negedge clk);
    chk("rej_no_write", {lut_wr_adr, lut_wr_data}, {11'h2A5, 32'hDEADBEEF});

    // empty batch completes without tpu_start
    push_done(4'b0001, 20'h0, 0);
    do_start(10'd0, 10'd5);
    wait_state(2'd3, 10, "zero_done");
    @(negedge clk);

    // start with abort in the same cycle is dropped
    n0 = n_start;
    ctl[0] = 1'b0; ctl[7] = 1'b0;
    repeat (2) @(negedge clk);
    ctl[0] = 1'b1; ctl[7] = 1'b1;
    repeat (4) @(negedge clk);
    chk("sa_state", status[7:6], 2'd0);
    chk("sa_keep_done", status[1], 1'b1);
    chk("sa_starts", n_start, n0);
    ctl[7] = 1'b0;

    // FIFO backpressure
    fifo_used = 10'd1000; resp_dly = 2;
    n0 = n_start;
    push_done(4'b0001, 20'h0, 1);
    do_start(10'd1, 10'd1);
    wait_state(2'd1, 10, "stall_issue");
    repeat (5) @(negedge clk);
    chk("stall_state", status[7:6], 2'd1);
    chk("stall_bit", status[5], 1'b1);
    chk("stall_nostart", n_start, n0);
    fifo_used = 10'd999;
    @(negedge clk);
    chk("stall_release", tpu_start, 1'b1);
    wait_state(2'd3, 20, "stall_done");
    fifo_used = 10'd0;
    @(negedge clk);

    // ECC counting
    resp_dly = 1;
    flag_q.push_back(3'b100); flag_q.push_back(3'b100); flag_q.push_back(3'b010);
    push_done(4'b0001, {10'd2, 10'd1}, 3);
    do_start(10'd1, 10'd3);
    wait_state(2'd3, 100, "ecc_done");
    @(negedge clk);

    // corrected count saturates
    resp_flags = 3'b010;
    push_done(4'b0001, {10'd0, 10'd1023}, 1100);
    do_start(10'd2, 10'd550);
    wait_state(2'd3, 8000, "sat_done");
    @(negedge clk);
    resp_flags = 3'b000;

    // abort wins over a coincident tpu_done
    resp_en = 1'b0;
    do_start(10'd2, 10'd3);
    wait_start(20, "abort_start1");
    man_flags = 3'b010;
    @(posedge clk); #1 man_done = 1'b1;
    @(posedge clk); #1 man_done = 1'b0;
    @(negedge clk);
    wait_start(20, "abort_start2");
    ctl[7] = 1'b1;
    @(posedge clk); #1 man_done = 1'b1;
    @(posedge clk); #1 man_done = 1'b0;
    @(negedge clk);
    chk("abort_state", status[7:6], 2'd0);
    chk("abort_bit", status[2], 1'b1);
    chk("abort_err", err_cnt, {10'd0, 10'd1});
    chk("abort_busy", busy, 1'b0);
    ctl[7] = 1'b0;
    man_flags = 3'b000;
    @(negedge clk);

    // timeout after 16 WAIT cycles
    push_done(4'b0101, 20'h0, 1);
    do_start(10'd1, 10'd1);
    w = 0;
    for (int i = 0; i < 100 && status[7:6] != 2'd3; i++) begin
      @(negedge clk);
      if (status[7:6] == 2'd2) w++;
    end
    chk("tmo_wait_cycles", w, 16);
    chk("tmo_bit", status[3], 1'b1);
    @(negedge clk);

    // reset mid-WAIT
    do_start(10'd1, 10'd1);
    wait_state(2'd2, 10, "rst_wait");
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0; ctl = 8'h00;
    #1;
    chk("rst_mid_lut", {lut_wr_en, lut_wr_adr, lut_wr_data}, 64'h0);
    chk("rst_mid_ctl", {tpu_start, busy, err_cnt, status}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("done_q_empty", done_q.size(), 0);
    chk("lut_q_empty", lut_q.size(), 0);
    chk("flag_q_empty", flag_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
